// File: rtl/audio_buffer_ctrl.sv
// audio_buffer_ctrl: stereo sample buffer sequencer.
// Passthrough, fixed-delay FIFO and record/reverse playback.
module audio_buffer_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] delay_len,
    input  logic                  read_ready,
    input  logic                  write_ready,
    input  logic [DATA_WIDTH-1:0] readdata_left,
    input  logic [DATA_WIDTH-1:0] readdata_right,
    output logic                  read,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] writedata_left,
    output logic [DATA_WIDTH-1:0] writedata_right,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic [2:0]            state,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int FW = ADDR_WIDTH + 1;
    localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PASS  = 3'd1,
        S_DFILL = 3'd2,
        S_DRUN  = 3'd3,
        S_REC   = 3'd4,
        S_PLAY  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_HOLD,
        SEL_MEM
    } sel_t;

    state_t cur;
    state_t nxt;
    sel_t   out_sel;

    logic [DATA_WIDTH-1:0] mem_l [DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] delay_q;
    logic [DATA_WIDTH-1:0] hold_l;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [FW-1:0]         fill_nxt;

    logic in_beat;
    logic out_beat;
    logic full;
    logic empty;
    logic do_push;
    logic do_fifo_pop;
    logic do_lifo_pop;
    logic set_over;
    logic set_under;

    // write_ready is masked during the strobe cycle (cooldown)
    assign read     = read_ready;
    assign in_beat  = read_ready;
    assign out_beat = write_ready & ~write;
    assign full     = (fill_level == FULL_LVL);
    assign empty    = (fill_level == '0);
    assign state    = cur;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next state and per-cycle datapath decisions
    always_comb begin
        nxt         = cur;
        out_sel     = SEL_ZERO;
        rd_addr     = rd_ptr;
        do_push     = 1'b0;
        do_fifo_pop = 1'b0;
        do_lifo_pop = 1'b0;
        set_over    = 1'b0;
        set_under   = 1'b0;
        if (start) begin
            unique case (mode)
                2'd1: begin
                    if (delay_len == '0) begin
                        nxt = S_DRUN;
                    end else begin
                        nxt = S_DFILL;
                    end
                end
                2'd2:    nxt = S_REC;
                default: nxt = S_PASS;
            endcase
        end else begin
            unique case (cur)
                S_PASS: out_sel = SEL_HOLD;
                S_DFILL, S_DRUN: begin
                    // pop sees the pre-push level: no bypass
                    do_push  = in_beat & ~full;
                    set_over = in_beat & full;
                    if (cur == S_DRUN && out_beat) begin
                        if (empty) begin
                            set_under = 1'b1;
                        end else begin
                            do_fifo_pop = 1'b1;
                            out_sel     = SEL_MEM;
                        end
                    end
                end
                S_REC: do_push = in_beat & ~full;
                S_PLAY: begin
                    if (out_beat) begin
                        if (empty) begin
                            set_under = 1'b1;
                        end else begin
                            do_lifo_pop = 1'b1;
                            out_sel     = SEL_MEM;
                            rd_addr     = wr_ptr - ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
        fill_nxt = fill_level
                 + FW'(do_push)
                 - FW'(do_fifo_pop | do_lifo_pop);
        if (!start) begin
            unique case (cur)
                S_DFILL: begin
                    if (fill_nxt >= {1'b0, delay_q}) begin
                        nxt = S_DRUN;
                    end
                end
                S_REC: begin
                    if (fill_nxt == FULL_LVL) begin
                        nxt = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (do_lifo_pop && fill_nxt == '0) begin
                        nxt = S_REC;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sample memory, not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_l[wr_ptr] <= readdata_left;
            mem_r[wr_ptr] <= readdata_right;
        end
    end

    // Pointers, level, flags, holding register and output strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fill_level      <= '0;
            delay_q         <= '0;
            write           <= 1'b0;
            writedata_left  <= '0;
            writedata_right <= '0;
            hold_l          <= '0;
            hold_r          <= '0;
            overrun         <= 1'b0;
            underrun        <= 1'b0;
        end else if (start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            delay_q    <= delay_len;
            write      <= 1'b0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            write      <= out_beat;
            fill_level <= fill_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr + ONE;
            end else if (do_lifo_pop) begin
                wr_ptr <= wr_ptr - ONE;
            end
            if (do_fifo_pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (set_over) begin
                overrun <= 1'b1;
            end
            if (set_under) begin
                underrun <= 1'b1;
            end
            if (cur == S_PASS && in_beat) begin
                hold_l <= readdata_left;
                hold_r <= readdata_right;
            end
            if (out_beat) begin
                unique case (out_sel)
                    SEL_HOLD: begin
                        writedata_left  <= hold_l;
                        writedata_right <= hold_r;
                    end
                    SEL_MEM: begin
                        writedata_left  <= mem_l[rd_addr];
                        writedata_right <= mem_r[rd_addr];
                    end
                    default: begin
                        writedata_left  <= '0;
                        writedata_right <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/audio_buffer_ctrl.md
Name: audio_buffer_ctrl

Overview:
Sequences a stereo sample buffer between the audio codec core's read/write handshake and the output path. Captures filtered left/right samples into a 2×DEPTH on-chip memory and schedules playback in one of three modes: passthrough, fixed delay (FIFO) or reverse (record-then-LIFO playback). Sits between the per-channel average filters and the codec writedata ports. Also owns the read/write handshake, the pointers, the fill level and the error flags.

Parameters:
DATA_WIDTH, 24, sample width per channel (signed)
ADDR_WIDTH, 7, buffer address width; DEPTH = 2**ADDR_WIDTH = 128 samples per channel

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; flushes buffer and latches mode/delay_len
mode  in  2  0=PASS, 1=DELAY, 2=REVERSE, 3=reserved (treated as PASS)
delay_len  in  ADDR_WIDTH  DELAY-mode depth in samples, latched on start
read_ready  in  1  codec has a new input sample pair
write_ready  in  1  codec can accept an output sample pair
readdata_left  in  DATA_WIDTH  signed input sample, left
readdata_right  in  DATA_WIDTH  signed input sample, right
read  out  1  input acknowledge, = read_ready (combinational)
write  out  1  registered one-cycle output strobe
writedata_left  out  DATA_WIDTH  registered signed output sample, left
writedata_right  out  DATA_WIDTH  registered signed output sample, right
fill_level  out  ADDR_WIDTH+1  stored sample pairs, 0..DEPTH
state  out  3  current FSM state code
overrun  out  1  sticky: sample dropped because buffer full
underrun  out  1  sticky: write served with empty buffer

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wr_ptr=rd_ptr=0, fill_level=0, write=0, writedata_*=0, overrun=underrun=0, latched mode=PASS, latched delay_len=0. Memory contents are not reset.
- Input beat: a cycle with read_ready=1. Output beat: a cycle with write_ready=1 and write=0. write_ready is ignored while write=1, giving one cycle of cooldown.
- On an output beat, the next edge sets write=1 and loads writedata_*; write returns to 0 on the following edge. Latency is 1 cycle from write_ready to strobe.
- FSM states:
  - IDLE (0): output beats return 0. Exits only on start.
  - PASS (1): each input beat stores the pair in a one-deep holding register; output beats return the holding register. fill_level stays 0.
  - DFILL (2): input beats push to FIFO; output beats return 0. Moves to DRUN when fill_level reaches latched delay_len. delay_len=0 goes straight to DRUN.
  - DRUN (3): input beats push, output beats pop (oldest first).
  - REC (4): input beats push; output beats return 0. Moves to PLAY on the edge where fill_level becomes DEPTH.
  - PLAY (5): output beats pop the newest sample (LIFO, rd from wr_ptr-1 downward); input beats are discarded without setting overrun. Moves to REC on the edge where fill_level becomes 0.
- start (any state, including mid-playback): on the next edge, pointers=0, fill_level=0, flags cleared, write=0. Mode and delay_len are latched, and the FSM goes to PASS, DFILL or REC. Beats arriving in the start cycle are ignored.
- Simultaneous input and output beat in DFILL/DRUN: both are performed and fill_level is unchanged. The pop uses fill_level from before the push, so an empty FIFO returns 0 and sets underrun (no same-cycle bypass).
- Full FIFO (fill_level=DEPTH) on an input beat in DFILL/DRUN: the sample is dropped, overrun=1. A simultaneous pop still occurs.
- Empty FIFO on an output beat in DRUN: writedata=0, underrun=1, pointers unchanged.
- Pointers wrap modulo DEPTH. fill_level never exceeds DEPTH and never goes below 0.
- The buffer is a single-port read per output beat. Read data is registered straight into writedata_* and held until the next output beat.

Test Plan:
1. Reset then start with mode=0; input L=0x000123,R=0xFFFF00, then write_ready pulse -> write=1 one cycle later, writedata_left=0x000123, writedata_right=0xFFFF00, fill_level=0.
2. Start with mode=1, delay_len=4; 4 input beats (values 1..4) with interleaved output beats -> first 4 outputs are 0; state goes 2->3 after the 4th input; the next output beat returns 1; fill_level=4 after the 4th input.
3. DELAY with delay_len=0 and an empty FIFO: simultaneous read_ready and write_ready -> output 0, underrun=1, fill_level=1.
4. DELAY with no output beats: 129 input beats -> fill_level=128, overrun=1, 129th sample absent from later pops.
5. Start with mode=2; 128 input beats of value k -> state=5; the next 128 output beats return 128,127,...,1; then state=4 and fill_level=0.
6. Mid-PLAY start pulse with mode=0; write_ready asserted in the same cycle as start -> no strobe; fill_level=0, flags=0, state=1; the next output beat returns the latest held sample.
